priority_encoder_rr: RTL and testbench
======================================

# priority_encoder_rr

Parametrised, registered N-to-log2(N) priority encoder for request vectors, with ready/valid handshakes on both sides. It supports fixed-priority and round-robin modes. It reports multi-hot and all-zero inputs instead of producing undefined codes. It sits between request-collecting logic and a single downstream consumer, and replaces the 4-to-2 combinational encoder wherever widths above 4, back-pressure or fair arbitration are needed.

## Interface
- N, default 8: request vector width; legal range 2..256; need not be a power of two.
- W, default $clog2(N): output code width; derived, never overridden.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_in  input  N  request vector; bit i set means index i is requesting.
- in_valid  input  1  req_in and rr_mode are valid this cycle.
- in_ready  output  1  block can accept an input this cycle.
- rr_mode  input  1  0 = fixed priority (lowest index wins); 1 = round-robin.
- enc_out  output  W  encoded winning index.
- multi_hot  output  1  more than one bit was set in the accepted req_in.
- none  output  1  the accepted req_in was all zero.
- out_valid  output  1  enc_out, multi_hot and none are valid.
- out_ready  input  1  downstream accepts the result this cycle.

## Operation
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational and gives full throughput of one result per cycle.
- Fixed mode:
  - Winner is the lowest set index of req_in.
  - Examples: 4'b0001 -> 0, 4'b1000 -> 3, 4'b1011 -> 0.
- Round-robin mode:
  - Internal pointer ptr (W bits, range 0..N-1).
  - The search starts at ptr and ascends modulo N; the first set bit wins.
- Pointer update:
  - On every accepted non-zero input in either mode, ptr <= (winner == N-1) ? 0 : winner+1.
  - ptr wraps at N, not at 2^W.
  - The update in fixed mode keeps state coherent across mode switches.
- All-zero input:
  - The input is still accepted and a result is produced: enc_out = 0, none = 1, multi_hot = 0.
  - ptr is unchanged.
- multi_hot = 1 exactly when popcount(req_in) >= 2 at acceptance.
- rr_mode is sampled only at acceptance. Changing it while a result is stalled has no effect on the stalled result.
- Result register:
  - Loaded on accept.
  - When out_valid && !out_ready, enc_out, multi_hot, none and out_valid hold stable.
  - req_in is ignored while stalled.
- out_valid clearing:
  - out_valid falls after out_ready is high with no simultaneous accept.
  - Simultaneous drain and accept: new result loaded, out_valid stays 1.

## Timing
- Latency: 1 cycle. An input accepted at edge k appears on the outputs after edge k, with out_valid = 1 in cycle k+1.
- Reset values: out_valid = 0, enc_out = 0, multi_hot = 0, none = 0, ptr = 0.
- in_ready = 1 in the first cycle after reset.
- Reset mid-operation: rst wins over every other event in the same cycle.
  - A stalled result is discarded, out_valid = 0.
  - An in_valid in the reset cycle is not accepted.
- No combinational path from req_in to any output.
- The only combinational input-to-output path is out_ready -> in_ready.
- Non-power-of-two N: enc_out never exceeds N-1 and ptr never exceeds N-1.

## Test plan
- Fixed mode, N=4, out_ready = 1, inputs 0001, 0010, 0100, 1000, 1011 on consecutive cycles:
  - enc_out = 0, 1, 2, 3, 0, one cycle later each.
  - multi_hot = 1 only for 1011.
  - out_valid continuous, in_ready constantly 1.
- Round-robin wrap, N=4, rr_mode = 1, req_in = 1011 four times:
  - enc_out = 0, 1, 3, 0.
  - ptr after each = 1, 2, 0, 1.
- All-zero input in rr mode after a grant of 2: enc_out = 0, none = 1, next grant search still starts at 3.
- Back-pressure, N=8:
  - Accept 8'h10, then hold out_ready = 0 for 3 cycles while presenting 8'h01 with in_valid = 1.
  - enc_out stays 4 and in_ready = 0 throughout.
  - Raise out_ready: 8'h01 is accepted that cycle, and enc_out = 0 follows.
- Non-power-of-two, N=5, W=3, rr mode:
  - req_in = 5'b10000 -> enc_out = 4, ptr wraps to 0.
  - Next req_in = 5'b10001 -> enc_out = 0.
- Reset mid-stall: result valid with out_ready = 0, then assert rst for one cycle with in_valid = 1.
  - out_valid = 0 and ptr = 0 after the edge.
  - No input is accepted in the reset cycle.
  - in_ready = 1 in the next cycle.

Source files
------------

// File: rtl/priority_encoder_rr_if.sv
// Request/result bundle for the registered priority encoder.
// Carries the input handshake (req_in/in_valid/in_ready) and the result handshake.
// master = request producer + result consumer, slave = the encoder itself.
interface priority_encoder_rr_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] req_in;
  logic         in_valid;
  logic         in_ready;
  logic         rr_mode;
  logic [W-1:0] enc_out;
  logic         multi_hot;
  logic         none;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output req_in, in_valid, rr_mode, out_ready,
    input  in_ready, enc_out, multi_hot, none, out_valid
  );

  modport slave (
    input  req_in, in_valid, rr_mode, out_ready,
    output in_ready, enc_out, multi_hot, none, out_valid
  );
endinterface

// File: rtl/priority_encoder_rr.sv
// Registered N-to-log2(N) priority encoder, fixed-priority or round-robin, flags multi-hot/all-zero.
// Latency: one cycle from accept to out_valid; one result per cycle sustained.
// Backpressure: in_ready = !out_valid || out_ready; a stalled result holds and req_in is ignored.
module priority_encoder_rr #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  priority_encoder_rr_if.slave bus
);

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);
  localparam logic [W-1:0] ONE_W    = W'(1);
  localparam logic [N-1:0] ONE_N    = N'(1);

  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] enc_q, enc_d;
  logic         multi_hot_q, multi_hot_d;
  logic         none_q, none_d;
  logic         out_valid_q, out_valid_d;

  logic         in_ready;
  logic         accept;
  logic         req_any;
  logic [W-1:0] start_idx;
  logic [N-1:0] upper_req;
  logic [N-1:0] search_req;
  logic [W-1:0] winner;

  // Only out_ready reaches in_ready combinationally; everything else is registered.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  assign req_any  = |bus.req_in;

  // Split requests at the search start: bits at/above start win first, else wrap to bit 0.
  always_comb begin
    start_idx  = bus.rr_mode ? ptr_q : '0;
    upper_req  = '0;
    for (int i = 0; i < N; i++) begin
      upper_req[i] = bus.req_in[i] && (i >= int'(start_idx));
    end
    search_req = (|upper_req) ? upper_req : bus.req_in;
  end

  // Lowest set bit of the selected search vector (descending scan, last hit wins).
  always_comb begin
    winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (search_req[i]) winner = W'(i);
    end
  end

  // Next state: load a result on accept, drop out_valid on a drain with no new accept.
  always_comb begin
    ptr_d       = ptr_q;
    enc_d       = enc_q;
    multi_hot_d = multi_hot_q;
    none_d      = none_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = 1'b1;
      enc_d       = req_any ? winner : '0;
      none_d      = !req_any;
      multi_hot_d = |(bus.req_in & (bus.req_in - ONE_N));
      // Pointer advances in both modes so a later switch to round-robin stays fair;
      // wrap is at N, not 2^W, so non-power-of-two widths never produce an illegal index.
      if (req_any) begin
        ptr_d = (winner == LAST_IDX) ? '0 : winner + ONE_W;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State register; reset overrides any accept or drain in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      enc_q       <= '0;
      multi_hot_q <= 1'b0;
      none_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      enc_q       <= enc_d;
      multi_hot_q <= multi_hot_d;
      none_q      <= none_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.enc_out   = enc_q;
  assign bus.multi_hot = multi_hot_q;
  assign bus.none      = none_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Bench for priority_encoder_rr: N=4, N=5 and N=8 instances share one stimulus stream.
// Each instance has a transaction-level reference model checked every cycle,
// plus directed scenarios with hand-derived expected values.
module tb_priority_encoder_rr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req_drv = '0;
  logic       in_valid_drv = 1'b0;
  logic       rr_drv = 1'b0;
  logic       out_ready_drv = 1'b0;
  bit         chk_en = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gen_inst
    localparam int NN = (g == 0) ? 4 : (g == 1) ? 5 : 8;

    priority_encoder_rr_if #(.N(NN)) bus ();

    priority_encoder_rr #(.N(NN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.req_in    = req_drv[NN-1:0];
    assign bus.in_valid  = in_valid_drv;
    assign bus.rr_mode   = rr_drv;
    assign bus.out_ready = out_ready_drv;

    logic [NN-1:0] r_n;
    assign r_n = req_drv[NN-1:0];

    bit exp_valid = 1'b0;
    int exp_enc   = 0;
    bit exp_mh    = 1'b0;
    bit exp_none  = 1'b0;
    int exp_ptr   = 0;

    // First requesting index walking upward from start, modulo NN.
    function automatic int pick(input logic [NN-1:0] r, input int start);
      for (int k = 0; k < NN; k++) begin
        int idx = (start + k) % NN;
        if (r[idx]) return idx;
      end
      return 0;
    endfunction

    // Reference model of the result register and the arbitration pointer.
    always @(posedge clk) begin
      if (rst) begin
        exp_valid <= 1'b0;
        exp_enc   <= 0;
        exp_mh    <= 1'b0;
        exp_none  <= 1'b0;
        exp_ptr   <= 0;
      end else if (in_valid_drv && (!exp_valid || out_ready_drv)) begin
        exp_valid <= 1'b1;
        if (r_n == '0) begin
          exp_enc  <= 0;
          exp_none <= 1'b1;
          exp_mh   <= 1'b0;
        end else begin
          exp_enc  <= pick(r_n, rr_drv ? exp_ptr : 0);
          exp_none <= 1'b0;
          exp_mh   <= ($countones(r_n) >= 2);
          exp_ptr  <= (pick(r_n, rr_drv ? exp_ptr : 0) + 1) % NN;
        end
      end else if (out_ready_drv) begin
        exp_valid <= 1'b0;
      end
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge clk) begin
      if (chk_en) begin
        chk($sformatf("N%0d out_valid", NN), 32'(bus.out_valid), 32'(exp_valid));
        chk($sformatf("N%0d in_ready", NN), 32'(bus.in_ready), 32'(!exp_valid || out_ready_drv));
        chk($sformatf("N%0d ptr", NN), 32'(dut.ptr_q), 32'(exp_ptr));
        if (exp_valid) begin
          chk($sformatf("N%0d enc_out", NN), 32'(bus.enc_out), 32'(exp_enc));
          chk($sformatf("N%0d multi_hot", NN), 32'(bus.multi_hot), 32'(exp_mh));
          chk($sformatf("N%0d none", NN), 32'(bus.none), 32'(exp_none));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] r, input logic v, input logic m, input logic o);
    req_drv       = r;
    in_valid_drv  = v;
    rr_drv        = m;
    out_ready_drv = o;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    #1;
  endtask

  logic [7:0] t1_req [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0B};
  int         t1_enc [5] = '{0, 1, 2, 3, 0};
  int         t2_enc [4] = '{0, 1, 3, 0};
  int         t2_ptr [4] = '{1, 2, 0, 1};

  initial begin
    // Power-on reset
    rst = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst out_valid", 32'(gen_inst[2].bus.out_valid), 32'd0);
    chk("rst enc_out", 32'(gen_inst[2].bus.enc_out), 32'd0);
    chk("rst multi_hot", 32'(gen_inst[2].bus.multi_hot), 32'd0);
    chk("rst none", 32'(gen_inst[2].bus.none), 32'd0);
    chk("rst ptr", 32'(gen_inst[2].dut.ptr_q), 32'd0);
    rst = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst in_ready", 32'(gen_inst[2].bus.in_ready), 32'd1);
    chk_en = 1'b1;

    // Fixed priority, N=4, streaming
    for (int k = 0; k < 5; k++) begin
      drive(t1_req[k], 1'b1, 1'b0, 1'b1);
      chk("fix in_ready", 32'(gen_inst[0].bus.in_ready), 32'd1);
      tick();
      chk("fix enc", 32'(gen_inst[0].bus.enc_out), 32'(t1_enc[k]));
      chk("fix mh", 32'(gen_inst[0].bus.multi_hot), 32'(k == 4));
      chk("fix vld", 32'(gen_inst[0].bus.out_valid), 32'd1);
    end

    // Round-robin wrap, N=4
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(8'h0B, 1'b1, 1'b1, 1'b1);
      tick();
      chk("rr enc", 32'(gen_inst[0].bus.enc_out), 32'(t2_enc[k]));
      chk("rr ptr", 32'(gen_inst[0].dut.ptr_q), 32'(t2_ptr[k]));
    end

    // All-zero after a grant of 2: pointer stays at 3
    drive(8'h04, 1'b1, 1'b1, 1'b1);
    tick();
    chk("zero pre enc", 32'(gen_inst[0].bus.enc_out), 32'd2);
    drive(8'h00, 1'b1, 1'b1, 1'b1);
    tick();
    chk("zero enc", 32'(gen_inst[0].bus.enc_out), 32'd0);
    chk("zero none", 32'(gen_inst[0].bus.none), 32'd1);
    chk("zero mh", 32'(gen_inst[0].bus.multi_hot), 32'd0);
    chk("zero ptr", 32'(gen_inst[0].dut.ptr_q), 32'd3);
    drive(8'h0F, 1'b1, 1'b1, 1'b1);
    tick();
    chk("zero next enc", 32'(gen_inst[0].bus.enc_out), 32'd3);

    // Back-pressure, N=8
    drive(8'h10, 1'b1, 1'b0, 1'b1);
    tick();
    chk("bp first enc", 32'(gen_inst[2].bus.enc_out), 32'd4);
    for (int k = 0; k < 3; k++) begin
      drive(8'h01, 1'b1, 1'b0, 1'b0);
      chk("bp in_ready", 32'(gen_inst[2].bus.in_ready), 32'd0);
      tick();
      chk("bp hold enc", 32'(gen_inst[2].bus.enc_out), 32'd4);
      chk("bp hold vld", 32'(gen_inst[2].bus.out_valid), 32'd1);
    end
    drive(8'h01, 1'b1, 1'b1, 1'b1);
    chk("bp release rdy", 32'(gen_inst[2].bus.in_ready), 32'd1);
    tick();
    chk("bp release enc", 32'(gen_inst[2].bus.enc_out), 32'd0);

    // Non-power-of-two, N=5
    drive(8'h10, 1'b1, 1'b1, 1'b1);
    tick();
    chk("n5 enc4", 32'(gen_inst[1].bus.enc_out), 32'd4);
    chk("n5 ptr wrap", 32'(gen_inst[1].dut.ptr_q), 32'd0);
    drive(8'h11, 1'b1, 1'b1, 1'b1);
    tick();
    chk("n5 enc0", 32'(gen_inst[1].bus.enc_out), 32'd0);

    // Reset while a result is stalled, with in_valid high
    drive(8'h04, 1'b1, 1'b0, 1'b1);
    tick();
    drive(8'h02, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rs stalled vld", 32'(gen_inst[2].bus.out_valid), 32'd1);
    rst = 1'b1;
    drive(8'h08, 1'b1, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 1; g++) begin
      chk("rs vld n4", 32'(gen_inst[0].bus.out_valid), 32'd0);
      chk("rs vld n8", 32'(gen_inst[2].bus.out_valid), 32'd0);
      chk("rs ptr n4", 32'(gen_inst[0].dut.ptr_q), 32'd0);
      chk("rs ptr n8", 32'(gen_inst[2].dut.ptr_q), 32'd0);
      chk("rs in_ready", 32'(gen_inst[2].bus.in_ready), 32'd1);
    end
    tick();
    chk("rs no accept", 32'(gen_inst[2].bus.out_valid), 32'd0);

    // Randomized traffic against the models
    for (int c = 0; c < 800; c++) begin
      logic [7:0] r;
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0)      r = 8'h00;
      else if (sel <= 2) r = 8'(1 << $urandom_range(0, 7));
      else               r = 8'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      drive(r, $urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
      tick();
    end
    rst = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
